// File: rtl/merge_nu_pkg.sv
// Shared types for the two-lane merge stage.
package merge_nu_pkg;

   typedef enum logic {
      LANE0 = 1'b0,
      LANE1 = 1'b1
   } lane_e;

   localparam int DEFAULT_DEPTH = 4;

endpackage

// File: rtl/lane_fifo.sv
// Per-lane FIFO; occupancy held in a count register.
module lane_fifo
   import merge_nu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == (AW+1)'(DEPTH));
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/merge_nu.sv
// Two-lane merge: per-lane FIFOs, round-robin arbiter,
// registered output with source tag and beat counter.
module merge_nu
   import merge_nu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in0_valid,
   output logic             in0_ready,
   input  logic [WIDTH-1:0] in0_data,
   input  logic             in1_valid,
   output logic             in1_ready,
   input  logic [WIDTH-1:0] in1_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_lane,
   output logic [CNT_W-1:0] out_count
);

   logic [WIDTH-1:0] head0;
   logic [WIDTH-1:0] head1;
   logic             empty0;
   logic             empty1;
   logic             full0;
   logic             full1;
   logic             grant0;
   logic             grant1;
   logic             free;
   lane_e            prio;

   assign in0_ready = !full0;
   assign in1_ready = !full1;
   assign free      = !out_valid || out_ready;

   lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (in0_valid),
      .push_data (in0_data),
      .pop       (grant0),
      .pop_data  (head0),
      .empty     (empty0),
      .full      (full0)
   );

   lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (in1_valid),
      .push_data (in1_data),
      .pop       (grant1),
      .pop_data  (head1),
      .empty     (empty1),
      .full      (full1)
   );

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (free) begin
         unique case (1'b1)
            !empty0 && (empty1 || prio == LANE0): grant0 = 1'b1;
            !empty1 && (empty0 || prio == LANE1): grant1 = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_lane  <= LANE0;
         out_count <= '0;
         prio      <= LANE0;
      end else begin
         if (out_valid && out_ready) out_count <= out_count + 1'b1;
         if (grant0 || grant1) begin
            out_valid <= 1'b1;
            out_data  <= grant1 ? head1 : head0;
            out_lane  <= grant1 ? LANE1 : LANE0;
            prio      <= grant1 ? LANE0 : LANE1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
